// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC/IR ownership, shared imem port arbitration between fetch and loader.
// Optional fetch performance counter enabled by defining FETCH_PERF_COUNT_EN.
module fetch_sequencer #(
  parameter logic [31:0] START_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 12,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic              halt,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  input  logic              load_valid,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  output logic              load_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_re,
  output logic              imem_we,
  output logic [31:0]       imem_wdata,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4,
  output logic [31:0]       ir,
  output logic              ir_valid,
  output logic [1:0]        state
`ifdef FETCH_PERF_COUNT_EN
  ,
  output logic [31:0]       perf_fetch_count
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } state_t;

  state_t state_q;

  assign state    = state_q;
  assign pc_plus4 = pc + 32'd4;

  // Port arbitration. Gating with RESET keeps the memory quiet while reset is held.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    load_ready = 1'b0;
    imem_we    = 1'b0;
    imem_re    = 1'b0;
    imem_addr  = load_addr;
    imem_wdata = load_data;
    if (RESET) begin
      if (state_q == RUN) begin
        imem_addr = pc[ADDR_W+1:2];
        imem_re   = ~stall;
      end else begin
        load_ready = 1'b1;
        imem_we    = load_valid;
      end
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q          <= IDLE;
      pc               <= START_PC;
      ir               <= NOP_WORD;
      ir_valid         <= 1'b0;
`ifdef FETCH_PERF_COUNT_EN
      perf_fetch_count <= 32'd0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            pc      <= START_PC;
          end
        end
        HALTED: begin
          if (start) state_q <= RUN;
        end
        RUN: begin
          if (halt) begin
            state_q  <= HALTED;
            ir_valid <= 1'b0;
          end else if (branch_taken) begin
            // Redirect targets are word aligned; the low address bits are discarded.
            pc       <= branch_target & ~32'd3;
            ir       <= NOP_WORD;
            ir_valid <= 1'b0;
          end else if (!stall) begin
            ir       <= imem_rdata;
            ir_valid <= 1'b1;
            pc       <= pc_plus4;
`ifdef FETCH_PERF_COUNT_EN
            perf_fetch_count <= perf_fetch_count + 32'd1;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
